// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, internal instruction memory and the IF/ID register.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned redirects instead of truncating them.
module fetch_stage #(
    parameter int          MEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        out_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] pc,
    output logic [31:0] fetch_count,
    output logic        fault
);

    localparam int AW = $clog2(MEM_DEPTH);

    logic [31:0]   block [MEM_DEPTH];
    logic [AW-1:0] idx;
    logic          transfer;
    logic          stall;
    logic          halt;
    logic          bad_target;
    logic [31:0]   target;

    assign idx      = pc[AW+1:2];
    assign transfer = out_valid & out_ready;
    assign stall    = out_valid & ~out_ready;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q;

    assign bad_target = |redirect_target[1:0];
    assign target     = redirect_target;
    assign halt       = fault_q;
    assign fault      = fault_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else if (redirect_valid && bad_target) begin
            fault_q <= 1'b1;
        end
    end
`else
    logic unused_low;

    assign unused_low = ^redirect_target[1:0];
    assign bad_target = 1'b0;
    assign target     = {redirect_target[31:2], 2'b00};
    assign halt       = 1'b0;
    assign fault      = 1'b0;
`endif

    // A transfer in a redirect cycle still counts: the older word was taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            out_valid   <= 1'b0;
            out_instr   <= 32'h0;
            out_pc      <= 32'h0;
            fetch_count <= 32'h0;
        end else begin
            if (transfer) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (halt) begin
                out_valid <= 1'b0;
            end else if (redirect_valid) begin
                out_valid <= 1'b0;
                if (!bad_target) begin
                    pc <= target;
                end
            end else if (!stall) begin
                out_instr <= block[idx];
                out_pc    <= pc;
                out_valid <= 1'b1;
                pc        <= pc + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: vector table, corner sequences
// and a scoreboarded random run.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        out_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] pc;
    logic [31:0] fetch_count;
    logic        fault;

    fetch_stage #(.MEM_DEPTH(256), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .reset           (reset),
        .out_ready       (out_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .pc              (pc),
        .fetch_count     (fetch_count),
        .fault           (fault)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rdy;
        logic        rd;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic        e_v;
        logic [31:0] e_opc;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t        tv [18];
    logic [31:0] sbq [$];
    logic        sb_on = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] i);
        logic [7:0] b;
        b = i[7:0];
        return {8'hC3, b, ~b, b ^ 8'h5A};
    endfunction

    function automatic vec_t mk(input logic rdy, input logic rd,
                                input logic [31:0] tgt,
                                input logic [31:0] e_pc, input logic e_v,
                                input logic [31:0] e_opc,
                                input logic [31:0] e_cnt);
        vec_t v;
        v.rdy = rdy; v.rd = rd; v.tgt = tgt;
        v.e_pc = e_pc; v.e_v = e_v; v.e_opc = e_opc; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    // Scoreboard pops one expected PC for every DUT transfer.
    always @(posedge clk) begin
        if (sb_on && !reset && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL sb_extra: got pc %h expected none", out_pc);
            end else begin
                logic [31:0] e;
                e = sbq.pop_front();
                chk("sb_pc", out_pc, e);
                chk("sb_instr", out_instr, mem_word(e >> 2));
            end
        end
    end

    initial begin
        logic [31:0] m_pc;
        logic [31:0] m_opc;
        logic        m_v;
        logic [31:0] m_cnt;

        for (int i = 0; i < 256; i++) dut.block[i] = mem_word(i);

        tv[0]  = mk(1, 0, 0,            32'h4,        1, 32'h0,        0);
        tv[1]  = mk(1, 0, 0,            32'h8,        1, 32'h4,        1);
        tv[2]  = mk(1, 0, 0,            32'hC,        1, 32'h8,        2);
        tv[3]  = mk(0, 0, 0,            32'hC,        1, 32'h8,        2);
        tv[4]  = mk(0, 0, 0,            32'hC,        1, 32'h8,        2);
        tv[5]  = mk(0, 0, 0,            32'hC,        1, 32'h8,        2);
        tv[6]  = mk(1, 0, 0,            32'h10,       1, 32'hC,        3);
        tv[7]  = mk(1, 1, 32'h40,       32'h40,       0, 32'h0,        4);
        tv[8]  = mk(1, 0, 0,            32'h44,       1, 32'h40,       4);
        tv[9]  = mk(0, 1, 32'h80,       32'h80,       0, 32'h0,        4);
        tv[10] = mk(0, 0, 0,            32'h84,       1, 32'h80,       4);
        tv[11] = mk(1, 0, 0,            32'h88,       1, 32'h84,       5);
        tv[12] = mk(1, 1, 32'h3FC,      32'h3FC,      0, 32'h0,        6);
        tv[13] = mk(1, 0, 0,            32'h400,      1, 32'h3FC,      6);
        tv[14] = mk(1, 0, 0,            32'h404,      1, 32'h400,      7);
        tv[15] = mk(0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 0, 32'h0,        7);
        tv[16] = mk(1, 0, 0,            32'h0,        1, 32'hFFFFFFFC, 7);
        tv[17] = mk(1, 0, 0,            32'h4,        1, 32'h0,        8);

        do_reset();
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_count", fetch_count, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'h0);

        for (int i = 0; i < 18; i++) begin
            out_ready = tv[i].rdy;
            redirect_valid = tv[i].rd;
            redirect_target = tv[i].tgt;
            cyc();
            chk($sformatf("v%0d_pc", i), pc, tv[i].e_pc);
            chk($sformatf("v%0d_valid", i), {31'h0, out_valid},
                {31'h0, tv[i].e_v});
            chk($sformatf("v%0d_count", i), fetch_count, tv[i].e_cnt);
            if (tv[i].e_v) begin
                chk($sformatf("v%0d_out_pc", i), out_pc, tv[i].e_opc);
                chk($sformatf("v%0d_instr", i), out_instr,
                    mem_word(tv[i].e_opc >> 2));
            end
        end
        redirect_valid = 1'b0;

        // Misaligned redirect
        do_reset();
        out_ready = 1'b1;
        cyc();
        redirect_valid = 1'b1;
        redirect_target = 32'h42;
        cyc();
        redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mis_fault", {31'h0, fault}, 32'h1);
        chk("mis_valid", {31'h0, out_valid}, 32'h0);
        for (int i = 0; i < 3; i++) cyc();
        chk("mis_hold_valid", {31'h0, out_valid}, 32'h0);
        chk("mis_hold_fault", {31'h0, fault}, 32'h1);
        do_reset();
        chk("mis_clear", {31'h0, fault}, 32'h0);
`else
        chk("mis_pc", pc, 32'h40);
        chk("mis_fault", {31'h0, fault}, 32'h0);
        cyc();
        chk("mis_out_pc", out_pc, 32'h40);
        chk("mis_instr", out_instr, mem_word(16));
`endif

        // Reset during a stall with a redirect pending
        do_reset();
        out_ready = 1'b1;
        cyc();
        cyc();
        out_ready = 1'b0;
        cyc();
        reset = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h80;
        cyc();
        chk("rs_pc", pc, 32'h0);
        chk("rs_valid", {31'h0, out_valid}, 32'h0);
        chk("rs_count", fetch_count, 32'h0);
        reset = 1'b0;
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        cyc();
        chk("rs_first_pc", out_pc, 32'h0);
        chk("rs_first_instr", out_instr, mem_word(0));

        // Random traffic against a behavioural model
        do_reset();
        m_pc = 32'h0;
        m_opc = 32'h0;
        m_v = 1'b0;
        m_cnt = 32'h0;
        sb_on = 1'b1;
        for (int n = 0; n < 400; n++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_target = $urandom & 32'hFFFFFFFC;
            if (m_v && out_ready) begin
                sbq.push_back(m_opc);
                m_cnt = m_cnt + 1;
            end
            if (redirect_valid) begin
                m_pc = redirect_target;
                m_v = 1'b0;
            end else if (!m_v || out_ready) begin
                m_opc = m_pc;
                m_v = 1'b1;
                m_pc = m_pc + 4;
            end
            cyc();
        end
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        cyc();
        sb_on = 1'b0;
        chk("sb_left", sbq.size(), 32'h0);
        chk("sb_count", fetch_count, m_cnt);
        chk("sb_pc_end", pc, m_pc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
